// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to N_CDB of N_REQ completed results per cycle.
// Latency: 1 cycle from grant (req_valid & req_ready) to the registered CDB lane.
// Backpressure: denied requesters hold their result and retry; nothing is buffered here.
// Optional build macro CDB_ARB_PERF_EN adds the stall_cnt performance counter output.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_CDB  = 2,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ROB_W-1:0]  req_rob_index,
  input  logic [N_REQ*DATA_W-1:0] req_result,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_CDB-1:0]        cdb_valid,
  output logic [N_CDB*ROB_W-1:0]  cdb_rob_index,
  output logic [N_CDB*DATA_W-1:0] cdb_result
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // ptr names the requester with highest priority this cycle.
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        ptr_nxt;
  logic [N_CDB-1:0]        lane_vld;
  logic [N_CDB*ROB_W-1:0]  lane_rob;
  logic [N_CDB*DATA_W-1:0] lane_res;

  // Scan requesters starting at ptr, hand the first N_CDB valid ones to lanes in scan order.
  always_comb begin
    int gcnt;
    req_ready = '0;
    lane_vld  = '0;
    lane_rob  = '0;
    lane_res  = '0;
    ptr_nxt   = ptr;
    gcnt      = 0;
    if (!rst && !flush) begin
      for (int j = 0; j < N_REQ; j++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if ((i == (int'(ptr) + j) % N_REQ) && req_valid[i] && (gcnt < N_CDB)) begin
            req_ready[i] = 1'b1;
            for (int k = 0; k < N_CDB; k++) begin
              if (k == gcnt) begin
                lane_vld[k]                  = 1'b1;
                lane_rob[k*ROB_W +: ROB_W]   = req_rob_index[i*ROB_W +: ROB_W];
                lane_res[k*DATA_W +: DATA_W] = req_result[i*DATA_W +: DATA_W];
              end
            end
            gcnt    = gcnt + 1;
            // Last granted requester wins the pointer; no grant leaves it unchanged.
            ptr_nxt = PTR_W'((i + 1) % N_REQ);
          end
        end
      end
    end
  end

  // Register the CDB lanes; idle lanes drop valid but keep their old payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      cdb_valid     <= '0;
      cdb_rob_index <= '0;
      cdb_result    <= '0;
    end else begin
      ptr       <= ptr_nxt;
      cdb_valid <= lane_vld;
      for (int k = 0; k < N_CDB; k++) begin
        if (lane_vld[k]) begin
          cdb_rob_index[k*ROB_W +: ROB_W]   <= lane_rob[k*ROB_W +: ROB_W];
          cdb_result[k*DATA_W +: DATA_W]    <= lane_res[k*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic stall_evt;
  assign stall_evt = !rst && !flush && |(req_valid & ~req_ready);

  // Count cycles in which some ready result had to wait, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (N_REQ=4, N_CDB=2): directed cases then randomized traffic.
// Reference model keeps a priority pointer and a queue of valid requesters in scan order.
// Requesters hold payload until granted, as the handshake requires.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_rob_index = '0;
  logic [63:0] req_result = '0;
  logic [3:0]  req_ready;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_index;
  logic [31:0] cdb_result;
`ifdef CDB_ARB_PERF_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(4), .N_CDB(2), .ROB_W(4), .DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_rob_index (req_rob_index),
    .req_result    (req_result),
    .req_ready     (req_ready),
    .cdb_valid     (cdb_valid),
    .cdb_rob_index (cdb_rob_index),
    .cdb_result    (cdb_result)
`ifdef CDB_ARB_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Per-FU payload presented on the request buses.
  logic [3:0]  rob [4];
  logic [15:0] res [4];

  // Reference model state.
  int          m_ptr = 0;
  logic [3:0]  e_rob [2];
  logic [15:0] e_res [2];
  int          m_stall = 0;
  logic [3:0]  obs_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check grants combinationally, then check registered lanes.
  task automatic step(input logic [3:0] v, input bit fl, input bit rs);
    int         q[$];
    int         g[$];
    logic [3:0] er;
    logic [1:0] ev;
    req_valid = v;
    flush     = fl;
    rst       = rs;
    for (int i = 0; i < 4; i++) begin
      req_rob_index[i*4 +: 4] = rob[i];
      req_result[i*16 +: 16]  = res[i];
    end
    // Valid requesters in priority order, first two win.
    if (!rs && !fl)
      for (int j = 0; j < 4; j++)
        if (v[(m_ptr + j) % 4]) q.push_back((m_ptr + j) % 4);
    while (q.size() > 0 && g.size() < 2) g.push_back(q.pop_front());
    er = '0;
    foreach (g[n]) er = er | (4'b0001 << g[n]);
    #1;
    obs_ready = req_ready;
    chk("req_ready", {60'd0, req_ready}, {60'd0, er});
    if (rs) begin
      m_ptr   = 0;
      e_rob   = '{4'd0, 4'd0};
      e_res   = '{16'd0, 16'd0};
      m_stall = 0;
      ev      = 2'b00;
    end else begin
      if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % 4;
      foreach (g[n]) begin
        e_rob[n] = rob[g[n]];
        e_res[n] = res[g[n]];
      end
      if (!fl && ((v & ~er) != 4'd0) && m_stall < 16'hFFFF) m_stall++;
      ev = (g.size() == 2) ? 2'b11 : (g.size() == 1) ? 2'b01 : 2'b00;
    end
    @(posedge clk);
    @(negedge clk);
    chk("cdb_valid", {62'd0, cdb_valid}, {62'd0, ev});
    chk("cdb_rob_index", {56'd0, cdb_rob_index}, {56'd0, e_rob[1], e_rob[0]});
    chk("cdb_result", {32'd0, cdb_result}, {32'd0, e_res[1], e_res[0]});
`ifdef CDB_ARB_PERF_EN
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
`endif
  endtask

  initial begin
    logic [3:0] pend;
    int         waitc [4];
    bit         fl;
    bit         rs;
    for (int i = 0; i < 4; i++) begin
      rob[i]   = 4'(i + 1);
      res[i]   = 16'h1000 * 16'(i + 1);
      waitc[i] = 0;
    end
    @(negedge clk);

    // Reset overrides all requests.
    step(4'b1111, 1'b0, 1'b1);
    chk("t1_ready", {60'd0, obs_ready}, 64'd0);
    chk("t1_cdb_valid", {62'd0, cdb_valid}, 64'd0);

    // Single requester FU2.
    rob[2] = 4'd5;
    res[2] = 16'h1234;
    step(4'b0100, 1'b0, 1'b0);
    chk("t2_ready", {60'd0, obs_ready}, 64'b0100);
    chk("t2_lane0", {44'd0, cdb_rob_index[3:0], cdb_result[15:0]}, 64'h5_1234);

    // ptr=3: FU3 then wrap to FU0.
    rob[3] = 4'd9;
    res[3] = 16'hAAAA;
    rob[0] = 4'd1;
    res[0] = 16'h0BEE;
    step(4'b1001, 1'b0, 1'b0);
    chk("t4_ready", {60'd0, obs_ready}, 64'b1001);
    chk("t4_lanes", {56'd0, cdb_rob_index}, 64'h19);

    // Move ptr to 0, then all four valid for two cycles.
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    chk("t3_ready_a", {60'd0, obs_ready}, 64'b0011);
    step(4'b1111, 1'b0, 1'b0);
    chk("t3_ready_b", {60'd0, obs_ready}, 64'b1100);

    // ptr=2, flush kills grants and holds ptr.
    step(4'b0010, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("t5_ready", {60'd0, obs_ready}, 64'd0);
    chk("t5_cdb_valid", {62'd0, cdb_valid}, 64'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("t5_ptr_held", {60'd0, obs_ready}, 64'b1100);
    step(4'b0000, 1'b0, 1'b0);

`ifdef CDB_ARB_PERF_EN
    step(4'b0000, 1'b0, 1'b1);
    repeat (4) step(4'b0111, 1'b0, 1'b0);
    chk("t6_stall_cnt", {48'd0, stall_cnt}, 64'd4);
`endif

    // Randomized traffic with held requests and occasional flush/reset.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          rob[i]  = 4'($urandom);
          res[i]  = 16'($urandom);
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 49) == 0);
      step(pend, fl, rs);
      for (int i = 0; i < 4; i++) begin
        if (rs) begin
          waitc[i] = 0;
        end else if (!fl && pend[i]) begin
          if (obs_ready[i]) begin
            waitc[i] = 0;
          end else begin
            waitc[i]++;
            chk("starvation", 64'(waitc[i] < 2), 64'd1);
          end
        end
        if (obs_ready[i]) pend[i] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
